fp_div_operand_prep: RTL and testbench
======================================

Name: fp_div_operand_prep

Overview:
Upstream stage of the single-precision divider (fpdiv). It accepts two IEEE-754 binary32 operands over a valid/ready handshake and classifies each one. It normalizes subnormal mantissas iteratively, then presents unpacked sign/exponent/mantissa fields to the divider. Special-case quotients (NaN, Inf, zero) are resolved here and flagged for bypass, so the divider core only sees finite, non-zero, normalized operands.

Parameters:
SHIFT_STEP, 1, max left-shift bits per NORM cycle per mantissa; legal values 1, 2, 4, 8.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  operand pair valid
in_ready  out  1  stage can accept operands
in_a  in  32  dividend, binary32
in_b  in  32  divisor, binary32
out_valid  out  1  unpacked result valid
out_ready  in  1  downstream accepts
out_sign  out  1  quotient sign = a[31]^b[31]
out_exp_a  out  10  unbiased dividend exponent, two's complement
out_exp_b  out  10  unbiased divisor exponent, two's complement
out_man_a  out  24  dividend mantissa, hidden bit explicit, bit23=1 when finite non-zero
out_man_b  out  24  divisor mantissa, same rule
out_bypass  out  1  quotient is special; downstream forwards out_quick
out_quick  out  32  special-case quotient, valid when out_bypass=1

Behaviour:
- Reset: state=IDLE; out_valid=0, out_bypass=0, all data outputs 0; in_ready=0 while rst=1.
- IDLE: in_ready=1. On in_valid&in_ready, register operands and classify each one as ZERO, SUB, NORM, INF or NAN.
- Special resolution, evaluated in priority order:
  - either operand NAN, 0/0 or Inf/Inf -> 0x7FC00000.
  - x/0 with x finite non-zero -> {sign,0x7F800000}.
  - Inf/finite -> {sign,0x7F800000}.
  - 0/non-zero-finite or finite/Inf -> {sign,31'h0}.
- If special: out_bypass=1, go to OUT; out_exp/out_man = 0.
- If not special and no SUB operand: exp = E-127, man = {1,frac}; go to OUT.
- If not special and any SUB operand: SUB exp initialised to -126, man = {0,frac}; go to NORM.
- NORM: each cycle, each mantissa with bit23=0 shifts left by min(SHIFT_STEP, its leading-zero count), and its exp decrements by the same amount. When both bit23=1, go to OUT.
- OUT: out_valid=1. All outputs are held stable until out_ready=1, then go to IDLE. in_ready=0 in NORM and OUT, so there is no overlap and throughput is at most one pair per 2 cycles.
- Latency, acceptance edge to out_valid: 1 cycle for normal or special operands; 1+ceil(lz/SHIFT_STEP) cycles with subnormals. Worst case at SHIFT_STEP=1 is 24 cycles (operand 0x00000001, lz=23).
- Exponent range: -149..+127, which fits 10-bit signed.
- Sign of zero/inf results follows out_sign; NaN is always the canonical positive qNaN with payload discarded.
- Reset asserted mid-NORM or in OUT: return to IDLE next edge, discard operands, out_valid=0 on that edge.
- in_valid held high while busy is not accepted; it is sampled again in IDLE.

Optional Feature:
FP_DIV_PREP_DAZ_EN
- Defined: subnormal inputs are classified as ZERO, with sign preserved. The NORM state and its shifter are not compiled, and latency is always 1.
- Undefined: full subnormal normalization as above.

Decomposition:
- fp_div_pkg:
  - class enum fp_class_e {ZERO,SUB,NORM,INF,NAN}
  - constants EXP_BIAS=127, EXP_MIN=-126, QNAN=32'h7FC00000, POS_INF=32'h7F800000
  - widths EXP_W=10, MAN_W=24
  - typedef struct fp_unpacked_t {sign, exp, man}
- One sub-module fp_classify: combinational, binary32 in -> fp_class_e plus raw exponent and fraction. It is instantiated twice.

Test Plan:
1. a=0x3F28F5C3 (0.66), b=0x3F028F5C (0.51) -> out_valid 1 cycle after accept; exp_a=-1, man_a=0xA8F5C3, exp_b=-1, man_b=0x828F5C, bypass=0.
2. a=0x00000001, b=0x3F800000 -> out_valid 24 cycles after accept (SHIFT_STEP=1); man_a=0x800000, exp_a=-149; man_b=0x800000, exp_b=0. With SHIFT_STEP=8, out_valid after 4 cycles with the same values.
3. Specials, each bypass=1, latency 1:
   - 0x00000000/0x00000000 -> quick=0x7FC00000
   - 0xBF800000/0x00000000 -> 0xFF800000
   - 0x7F800000/0xC0000000 -> 0xFF800000
   - 0x3F800000/0xFF800000 -> 0x80000000
4. Backpressure: out_ready=0 for 5 cycles with in_valid=1 and a new pair presented -> outputs stable, in_ready=0, new pair accepted only after the OUT handshake plus return to IDLE.
5. rst pulsed 10 cycles into NORM of scenario 2 -> out_valid never asserts; in_ready=1 the cycle after rst deasserts; the following pair from scenario 1 produces the scenario 1 result.
6. FP_DIV_PREP_DAZ_EN defined: a=0x00000001, b=0x3F800000 -> bypass=1, quick=0x00000000, latency 1.

Source files
------------

// File: rtl/fp_div_pkg.sv
// Shared types, constants and helpers for the binary32 divider operand-preparation stage.
package fp_div_pkg;

    localparam int EXP_W    = 10;
    localparam int MAN_W    = 24;
    localparam int EXP_BIAS = 127;

    localparam logic signed [EXP_W-1:0] EXP_MIN = -10'sd126;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        SUB  = 3'd1,
        NORM = 3'd2,
        INF  = 3'd3,
        NAN  = 3'd4
    } fp_class_e;

    typedef struct packed {
        logic                    sign;
        logic signed [EXP_W-1:0] exp;
        logic [MAN_W-1:0]        man;
    } fp_unpacked_t;

    function automatic logic [4:0] lzc24(input logic [MAN_W-1:0] m);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = MAN_W - 1; i >= 0; i--) begin
            if (!found) begin
                if (m[i]) begin
                    found = 1'b1;
                end else begin
                    n = n + 5'd1;
                end
            end else begin
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // Only finite non-zero classes carry an exponent/mantissa; everything else unpacks to zero.
    function automatic fp_unpacked_t unpack(input logic s, input fp_class_e c,
                                            input logic [7:0] e, input logic [22:0] f);
        fp_unpacked_t u;
        u = '0;
        case (c)
            NORM: begin
                u.sign = s;
                u.exp  = $signed({2'b00, e}) - 10'(EXP_BIAS);
                u.man  = {1'b1, f};
            end
            SUB: begin
                u.sign = s;
                u.exp  = EXP_MIN;
                u.man  = {1'b0, f};
            end
            default: begin
                u = '0;
            end
        endcase
        return u;
    endfunction

    function automatic fp_unpacked_t norm_step(input fp_unpacked_t u, input logic [4:0] step);
        fp_unpacked_t r;
        logic [4:0]   lz;
        logic [4:0]   sh;
        r  = u;
        lz = lzc24(u.man);
        sh = (lz < step) ? lz : step;
        if (!u.man[MAN_W-1]) begin
            r.man = u.man << sh;
            r.exp = u.exp - $signed({5'b00000, sh});
        end else begin
            r = u;
        end
        return r;
    endfunction

endpackage

// File: rtl/fp_div_operand_prep_classify.sv
// Combinational binary32 classifier: class, raw exponent, fraction and sign.
// With FP_DIV_PREP_DAZ_EN defined, subnormals are reported as ZERO.
module fp_classify
    import fp_div_pkg::*;
(
    input  logic [31:0] x,
    output fp_class_e   cls,
    output logic [7:0]  raw_exp,
    output logic [22:0] frac,
    output logic        sign
);

    assign raw_exp = x[30:23];
    assign frac    = x[22:0];
    assign sign    = x[31];

    // Decode the operand class from its exponent and fraction fields.
    always_comb begin
        cls = NORM;
        if (raw_exp == 8'h00) begin
            if (frac == 23'h0) begin
                cls = ZERO;
            end else begin
`ifdef FP_DIV_PREP_DAZ_EN
                cls = ZERO;
`else
                cls = SUB;
`endif
            end
        end else if (raw_exp == 8'hFF) begin
            if (frac == 23'h0) begin
                cls = INF;
            end else begin
                cls = NAN;
            end
        end else begin
            cls = NORM;
        end
    end

endmodule

// File: rtl/fp_div_operand_prep.sv
// Divider operand preparation: accepts a binary32 pair, resolves special quotients and
// normalizes subnormal mantissas SHIFT_STEP bits per cycle. FP_DIV_PREP_DAZ_EN flushes subnormals.
module fp_div_operand_prep
    import fp_div_pkg::*;
#(
    parameter int SHIFT_STEP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_a,
    input  logic [31:0]       in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp_a,
    output logic [EXP_W-1:0]  out_exp_b,
    output logic [MAN_W-1:0]  out_man_a,
    output logic [MAN_W-1:0]  out_man_b,
    output logic              out_bypass,
    output logic [31:0]       out_quick
);

    // PREP classifies the registered operands; this is the one cycle of latency for plain pairs.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
`ifndef FP_DIV_PREP_DAZ_EN
        ST_NORM = 2'd2,
`endif
        ST_OUT  = 2'd3
    } state_e;

    state_e       state_q, state_d;
    logic [31:0]  a_raw_q, a_raw_d;
    logic [31:0]  b_raw_q, b_raw_d;
    fp_unpacked_t a_q, a_d;
    fp_unpacked_t b_q, b_d;
    logic         sign_q, sign_d;
    logic         bypass_q, bypass_d;
    logic [31:0]  quick_q, quick_d;
    logic         out_valid_q, out_valid_d;

    fp_class_e    a_cls_s, b_cls_s;
    logic [7:0]   a_exp_s, b_exp_s;
    logic [22:0]  a_frac_s, b_frac_s;
    logic         a_sgn_s, b_sgn_s;
    logic         sign_s;
    logic         special_s;
    logic [31:0]  quick_s;

    fp_classify u_class_a (
        .x       (a_raw_q),
        .cls     (a_cls_s),
        .raw_exp (a_exp_s),
        .frac    (a_frac_s),
        .sign    (a_sgn_s)
    );

    fp_classify u_class_b (
        .x       (b_raw_q),
        .cls     (b_cls_s),
        .raw_exp (b_exp_s),
        .frac    (b_frac_s),
        .sign    (b_sgn_s)
    );

    assign sign_s = a_sgn_s ^ b_sgn_s;

    // Special-quotient resolution in priority order.
    always_comb begin
        special_s = 1'b1;
        quick_s   = 32'h0000_0000;
        if ((a_cls_s == NAN) || (b_cls_s == NAN) ||
            ((a_cls_s == ZERO) && (b_cls_s == ZERO)) ||
            ((a_cls_s == INF) && (b_cls_s == INF))) begin
            quick_s = QNAN;
        end else if (b_cls_s == ZERO) begin
            quick_s = {sign_s, POS_INF[30:0]};
        end else if (a_cls_s == INF) begin
            quick_s = {sign_s, POS_INF[30:0]};
        end else if ((a_cls_s == ZERO) || (b_cls_s == INF)) begin
            quick_s = {sign_s, 31'h0000_0000};
        end else begin
            special_s = 1'b0;
            quick_s   = 32'h0000_0000;
        end
    end

`ifndef FP_DIV_PREP_DAZ_EN
    localparam logic [4:0] STEP = 5'(SHIFT_STEP);

    fp_unpacked_t a_step_s, b_step_s;

    // One normalization step per mantissa; already-normalized mantissas pass through.
    always_comb begin
        a_step_s = norm_step(a_q, STEP);
        b_step_s = norm_step(b_q, STEP);
    end
`endif

    // Next-state and next-output computation.
    always_comb begin
        state_d     = state_q;
        a_raw_d     = a_raw_q;
        b_raw_d     = b_raw_q;
        a_d         = a_q;
        b_d         = b_q;
        sign_d      = sign_q;
        bypass_d    = bypass_q;
        quick_d     = quick_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_raw_d = in_a;
                    b_raw_d = in_b;
                    state_d = ST_PREP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PREP: begin
                sign_d = sign_s;
                if (special_s) begin
                    bypass_d    = 1'b1;
                    quick_d     = quick_s;
                    a_d         = '0;
                    b_d         = '0;
                    state_d     = ST_OUT;
                    out_valid_d = 1'b1;
                end else begin
                    bypass_d = 1'b0;
                    quick_d  = 32'h0000_0000;
                    a_d      = unpack(a_sgn_s, a_cls_s, a_exp_s, a_frac_s);
                    b_d      = unpack(b_sgn_s, b_cls_s, b_exp_s, b_frac_s);
`ifndef FP_DIV_PREP_DAZ_EN
                    if ((a_cls_s == SUB) || (b_cls_s == SUB)) begin
                        state_d = ST_NORM;
                    end else begin
                        state_d     = ST_OUT;
                        out_valid_d = 1'b1;
                    end
`else
                    state_d     = ST_OUT;
                    out_valid_d = 1'b1;
`endif
                end
            end
`ifndef FP_DIV_PREP_DAZ_EN
            ST_NORM: begin
                a_d = a_step_s;
                b_d = b_step_s;
                if (a_step_s.man[MAN_W-1] && b_step_s.man[MAN_W-1]) begin
                    state_d     = ST_OUT;
                    out_valid_d = 1'b1;
                end else begin
                    state_d = ST_NORM;
                end
            end
`endif
            ST_OUT: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    bypass_d    = 1'b0;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                bypass_d    = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_raw_q     <= 32'h0000_0000;
            b_raw_q     <= 32'h0000_0000;
            a_q         <= '0;
            b_q         <= '0;
            sign_q      <= 1'b0;
            bypass_q    <= 1'b0;
            quick_q     <= 32'h0000_0000;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_raw_q     <= a_raw_d;
            b_raw_q     <= b_raw_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sign_q      <= sign_d;
            bypass_q    <= bypass_d;
            quick_q     <= quick_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE) && !rst;
    assign out_valid  = out_valid_q;
    assign out_sign   = sign_q;
    assign out_exp_a  = a_q.exp;
    assign out_exp_b  = b_q.exp;
    assign out_man_a  = a_q.man;
    assign out_man_b  = b_q.man;
    assign out_bypass = bypass_q;
    assign out_quick  = quick_q;

endmodule

// File: tb/tb_fp_div_operand_prep.sv
// Scoreboard bench for fp_div_operand_prep: directed vectors push expectations, a monitor checks outputs.
module tb_fp_div_operand_prep;

    localparam int SHIFT_STEP = 1;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [9:0]  out_exp_a;
    logic [9:0]  out_exp_b;
    logic [23:0] out_man_a;
    logic [23:0] out_man_b;
    logic        out_bypass;
    logic [31:0] out_quick;

    fp_div_operand_prep #(.SHIFT_STEP(SHIFT_STEP)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sign   (out_sign),
        .out_exp_a  (out_exp_a),
        .out_exp_b  (out_exp_b),
        .out_man_a  (out_man_a),
        .out_man_b  (out_man_b),
        .out_bypass (out_bypass),
        .out_quick  (out_quick)
    );

    typedef struct {
        logic        sign;
        logic [9:0]  ea;
        logic [9:0]  eb;
        logic [23:0] ma;
        logic [23:0] mb;
        logic        byp;
        logic [31:0] q;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   seen  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input logic s, input int ea, input int eb,
                                input logic [23:0] ma, input logic [23:0] mb,
                                input logic byp, input logic [31:0] q, input int lat);
        exp_t e;
        e.sign = s;
        e.ea   = 10'(ea);
        e.eb   = 10'(eb);
        e.ma   = ma;
        e.mb   = mb;
        e.byp  = byp;
        e.q    = q;
        e.lat  = lat;
        e.acc  = 0;
        return e;
    endfunction

    function automatic int sub_lat(input int lz);
        return 1 + (lz + SHIFT_STEP - 1) / SHIFT_STEP;
    endfunction

    // Monitor: compares every presented output against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_valid: got out_valid=1 want 0 (cycle %0d)", cyc);
                end else begin
                    mon_e = sb[0];
                    if ({out_sign, out_exp_a, out_exp_b, out_man_a, out_man_b, out_bypass, out_quick} !==
                        {mon_e.sign, mon_e.ea, mon_e.eb, mon_e.ma, mon_e.mb, mon_e.byp, mon_e.q}) begin
                        bad++;
                        $display("FAIL result: got s=%0b ea=%h eb=%h ma=%h mb=%h byp=%0b q=%h want s=%0b ea=%h eb=%h ma=%h mb=%h byp=%0b q=%h",
                                 out_sign, out_exp_a, out_exp_b, out_man_a, out_man_b, out_bypass, out_quick,
                                 mon_e.sign, mon_e.ea, mon_e.eb, mon_e.ma, mon_e.mb, mon_e.byp, mon_e.q);
                    end
                    if (!seen) begin
                        seen = 1'b1;
                        total++;
                        if (cyc - mon_e.acc != mon_e.lat) begin
                            bad++;
                            $display("FAIL latency: got %0d want %0d", cyc - mon_e.acc, mon_e.lat);
                        end
                    end
                    total++;
                    if (in_ready !== 1'b0) begin
                        bad++;
                        $display("FAIL busy_ready: got in_ready=%0b want 0", in_ready);
                    end
                    if (out_ready) begin
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    // Presents a pair and waits (bounded) for acceptance; called just after a rising edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input exp_t e, input bit push);
        bit   accepted;
        exp_t ee;
        accepted = 1'b0;
        ee       = e;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        total++;
        if (accepted) begin
            ee.acc = cyc + 1;
            if (push) sb.push_back(ee);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end else begin
            bad++;
            $display("FAIL accept_timeout: got in_ready=0 want 1 for a=%h b=%h", a, b);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (sb.size() == 0) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
        end
        #1;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    exp_t e1, e2;
    int   lat2;
    int   rd;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 32'h0000_0000;
        in_b      = 32'h0000_0000;
        out_ready = 1'b1;

        e1 = mk(1'b0, -1, -1, 24'hA8F5C3, 24'h828F5C, 1'b0, 32'h0000_0000, 1);
`ifdef FP_DIV_PREP_DAZ_EN
        lat2 = 1;
        e2   = mk(1'b0, 0, 0, 24'h000000, 24'h000000, 1'b1, 32'h0000_0000, 1);
`else
        lat2 = sub_lat(23);
        e2   = mk(1'b0, -149, 0, 24'h800000, 24'h800000, 1'b0, 32'h0000_0000, lat2);
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({out_valid, out_bypass, out_quick, out_sign, out_exp_a, out_exp_b, out_man_a, out_man_b, in_ready} !== '0) begin
            bad++;
            $display("FAIL reset_state: got valid=%0b byp=%0b q=%h ma=%h mb=%h rdy=%0b want all 0",
                     out_valid, out_bypass, out_quick, out_man_a, out_man_b, in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        send(32'h3F28F5C3, 32'h3F028F5C, e1, 1'b1);
        send(32'h0000_0001, 32'h3F80_0000, e2, 1'b1);
        send(32'h0000_0000, 32'h0000_0000, mk(1'b0, 0, 0, 24'h0, 24'h0, 1'b1, 32'h7FC0_0000, 1), 1'b1);
        send(32'hBF80_0000, 32'h0000_0000, mk(1'b1, 0, 0, 24'h0, 24'h0, 1'b1, 32'hFF80_0000, 1), 1'b1);
        send(32'h7F80_0000, 32'hC000_0000, mk(1'b1, 0, 0, 24'h0, 24'h0, 1'b1, 32'hFF80_0000, 1), 1'b1);
        send(32'h3F80_0000, 32'hFF80_0000, mk(1'b1, 0, 0, 24'h0, 24'h0, 1'b1, 32'h8000_0000, 1), 1'b1);
        send(32'h7FC1_2345, 32'h3F80_0000, mk(1'b0, 0, 0, 24'h0, 24'h0, 1'b1, 32'h7FC0_0000, 1), 1'b1);
        send(32'hFF80_0000, 32'h7F80_0000, mk(1'b1, 0, 0, 24'h0, 24'h0, 1'b1, 32'h7FC0_0000, 1), 1'b1);
        send(32'h8000_0000, 32'h4000_0000, mk(1'b1, 0, 0, 24'h0, 24'h0, 1'b1, 32'h8000_0000, 1), 1'b1);
        send(32'hC040_0000, 32'h3E80_0000, mk(1'b1, 1, -2, 24'hC00000, 24'h800000, 1'b0, 32'h0, 1), 1'b1);
        send(32'h7F7F_FFFF, 32'h3F80_0000, mk(1'b0, 127, 0, 24'hFFFFFF, 24'h800000, 1'b0, 32'h0, 1), 1'b1);
`ifdef FP_DIV_PREP_DAZ_EN
        send(32'h3F80_0000, 32'h0040_0000, mk(1'b0, 0, 0, 24'h0, 24'h0, 1'b1, 32'h7F80_0000, 1), 1'b1);
`else
        send(32'h3F80_0000, 32'h0040_0000, mk(1'b0, 0, -127, 24'h800000, 24'h800000, 1'b0, 32'h0, sub_lat(1)), 1'b1);
`endif
        drain();

        // Backpressure: hold the first result while a second pair waits.
        out_ready = 1'b0;
        send(32'h3F28F5C3, 32'h3F028F5C, e1, 1'b1);
        fork
            send(32'hC040_0000, 32'h3E80_0000, mk(1'b1, 1, -2, 24'hC00000, 24'h800000, 1'b0, 32'h0, 1), 1'b1);
            begin
                repeat (6) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset during normalization discards the pair.
        if (lat2 > 2) begin
            rd = (lat2 >= 12) ? 10 : lat2 - 2;
            send(32'h0000_0001, 32'h3F80_0000, e2, 1'b0);
            repeat (rd) @(posedge clk);
        end else begin
            send(32'h0000_0001, 32'h3F80_0000, e2, 1'b1);
            drain();
            @(posedge clk);
        end
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL in_reset: got valid=%0b rdy=%0b want 0 0", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL post_reset: got rdy=%0b valid=%0b want 1 0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        send(32'h3F28F5C3, 32'h3F028F5C, e1, 1'b1);
        drain();
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
